uk101_video_gen: RTL and testbench



---
 rtl/uk101_video_gen.sv | 107 ++++++++++
 tb/tb_uk101_video_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uk101_video_gen.sv
// uk101_video_gen: scans a 64x16 character RAM through an 8x8 glyph ROM into a 1-bit pixel stream with sync/blank.
// Optional feature macro UK101_VIDEO_INVERT_EN adds an invert input that flips pixels in the active area.
module uk101_video_gen #(
  parameter int H_TOTAL    = 531,
  parameter int H_ACTIVE   = 384,
  parameter int HS_START   = 420,
  parameter int HS_WIDTH   = 40,
  parameter int V_TOTAL    = 312,
  parameter int V_ACTIVE   = 256,
  parameter int VS_START   = 280,
  parameter int VS_WIDTH   = 3,
  parameter int COL_OFFSET = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  output logic [9:0]  vram_addr,
  input  logic [7:0]  vram_data,
  output logic [10:0] charrom_addr,
  input  logic [7:0]  charrom_data,
`ifdef UK101_VIDEO_INVERT_EN
  input  logic        invert,
`endif
  output logic        pix,
  output logic        hsync,
  output logic        vsync,
  output logic        hblank,
  output logic        vblank
);

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_PRE  = 10'(H_TOTAL - 8);
  localparam logic [9:0] HS_ON  = 10'(HS_START);
  localparam logic [9:0] HS_OFF = 10'(HS_START + HS_WIDTH);
  localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
  localparam logic [8:0] V_ACT  = 9'(V_ACTIVE);
  localparam logic [8:0] VS_ON  = 9'(VS_START);
  localparam logic [8:0] VS_OFF = 9'(VS_START + VS_WIDTH);
  localparam logic [9:0] COL    = 10'(COL_OFFSET);

  logic [9:0] hcnt;
  logic [8:0] vcnt;
  logic [7:0] pattern;
  logic [7:0] shift;
  logic       wrap;
  logic [9:0] fpos;
  logic       fslot;
  logic [6:0] next_line;
  logic [6:0] fline;
  logic [9:0] cell_addr;
  logic       video_bit;

  // fpos is the position within the fetch window, which runs 8 pixels ahead of display.
  // The window for cell 0 lies at the end of the previous line, so it decodes the next vcnt.
  always_comb begin
    wrap      = (hcnt >= H_PRE);
    fpos      = wrap ? (hcnt - H_PRE) : (hcnt + 10'd8);
    fslot     = (fpos < H_ACT);
    next_line = (vcnt == V_LAST) ? 7'd0 : 7'((vcnt + 9'd1) >> 1);
    fline     = wrap ? next_line : vcnt[7:1];
    cell_addr = {fline[6:3], 6'b0} + COL + {3'b0, fpos[9:3]};
`ifdef UK101_VIDEO_INVERT_EN
    video_bit = shift[7] ^ invert;
`else
    video_bit = shift[7];
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hcnt         <= '0;
      vcnt         <= '0;
      pattern      <= '0;
      shift        <= '0;
      vram_addr    <= '0;
      charrom_addr <= '0;
      pix          <= 1'b0;
      hsync        <= 1'b0;
      vsync        <= 1'b0;
      hblank       <= 1'b1;
      vblank       <= 1'b1;
    end else if (ce_pix) begin
      if (hcnt == H_LAST) begin
        hcnt <= '0;
        vcnt <= (vcnt == V_LAST) ? 9'd0 : vcnt + 9'd1;
      end else begin
        hcnt <= hcnt + 10'd1;
      end

      // Outputs describe the counter value in effect before this edge.
      hblank <= (hcnt >= H_ACT);
      vblank <= (vcnt >= V_ACT);
      hsync  <= (hcnt >= HS_ON) && (hcnt < HS_OFF);
      vsync  <= (vcnt >= VS_ON) && (vcnt < VS_OFF);
      pix    <= video_bit & (hcnt < H_ACT) & (vcnt < V_ACT);

      if (fslot && fpos[2:0] == 3'd0) vram_addr <= cell_addr;
      if (fslot && fpos[2:0] == 3'd2) charrom_addr <= {vram_data, fline[2:0]};
      if (fslot && fpos[2:0] == 3'd4) pattern <= charrom_data;

      if (fslot && fpos[2:0] == 3'd7) shift <= pattern;
      else if (hcnt < H_ACT) shift <= {shift[6:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_uk101_video_gen.sv
// Bench for uk101_video_gen: reduced raster, random RAM/ROM contents, reference model of the display rules.
module tb_uk101_video_gen;

  localparam int HT  = 100;
  localparam int HA  = 64;
  localparam int HSS = 70;
  localparam int HSW = 10;
  localparam int VT  = 40;
  localparam int VA  = 32;
  localparam int VSS = 34;
  localparam int VSW = 3;
  localparam int COL = 13;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce_pix = 1'b0;
  logic [9:0]  vram_addr;
  logic [7:0]  vram_data;
  logic [10:0] charrom_addr;
  logic [7:0]  charrom_data;
  logic        invert_bit = 1'b0;
  logic        pix, hsync, vsync, hblank, vblank;

  logic [7:0] ram [1024];
  logic [7:0] rom [2048];

  int checks = 0;
  int errors = 0;
  int h_pos = 0;
  int v_pos = 0;
  int since_reset = 0;
  logic [4:0] exp_q[$];

  typedef struct {
    int         h;
    int         v;
    logic [3:0] exp;  // {hsync, vsync, hblank, vblank}
  } vec_t;
  vec_t tbl [15];

  uk101_video_gen #(
    .H_TOTAL(HT), .H_ACTIVE(HA), .HS_START(HSS), .HS_WIDTH(HSW),
    .V_TOTAL(VT), .V_ACTIVE(VA), .VS_START(VSS), .VS_WIDTH(VSW),
    .COL_OFFSET(COL)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ce_pix(ce_pix),
    .vram_addr(vram_addr),
    .vram_data(vram_data),
    .charrom_addr(charrom_addr),
    .charrom_data(charrom_data),
`ifdef UK101_VIDEO_INVERT_EN
    .invert(invert_bit),
`endif
    .pix(pix),
    .hsync(hsync),
    .vsync(vsync),
    .hblank(hblank),
    .vblank(vblank)
  );

  // Clock / memories
  always #10 clk = ~clk;

  always @(posedge clk) begin
    vram_data    <= ram[vram_addr];
    charrom_data <= rom[charrom_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at h=%0d v=%0d", h_pos, v_pos);
    $fatal(1, "watchdog");
  end

  // Reference model: what the screen shows at (h, v) and the sync/blank flags there
  function automatic logic [4:0] model(int h, int v, bit cold);
    logic       hb, vb, hs, vs, p;
    logic [7:0] code, glyph;
    int         c;
    hb = (h >= HA);
    vb = (v >= VA);
    hs = (h >= HSS) && (h < HSS + HSW);
    vs = (v >= VSS) && (v < VSS + VSW);
    p  = 1'b0;
    if (!hb && !vb) begin
      c = h / 8;
      if (cold && c == 0) glyph = 8'h00;
      else begin
        code  = ram[(v / 16) * 64 + COL + c];
        glyph = rom[int'(code) * 8 + (v / 2) % 8];
      end
      p = glyph[7 - (h % 8)] ^ invert_bit;
    end
    return {p, hs, vs, hb, vb};
  endfunction

  task automatic check(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at h=%0d v=%0d got %h expected %h", name, h_pos, v_pos, got, exp);
    end
  endtask

  // Driver tasks
  task automatic pulse();
    repeat ($urandom_range(0, 2)) @(negedge clk);
    ce_pix = 1'b1;
    @(negedge clk);
    ce_pix = 1'b0;
  endtask

  task automatic do_reset(int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      ce_pix = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("reset_outputs", 16'({pix, hsync, vsync, hblank, vblank}), 16'b00011);
    end
    check("reset_vram_addr", 16'(vram_addr), 16'd0);
    check("reset_charrom_addr", 16'(charrom_addr), 16'd0);
    ce_pix = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    check("post_reset_idle", 16'({pix, hsync, vsync, hblank, vblank}), 16'b00011);
    h_pos = 0;
    v_pos = 0;
    since_reset = 0;
  endtask

  // One pixel: scoreboard compare, table vectors, fetch address rules
  task automatic step();
    logic [4:0] e;
    int fp, fv, a;
    exp_q.push_back(model(h_pos, v_pos, since_reset < 8));
    pulse();
    e = exp_q.pop_front();
    check("pixel_outputs", 16'({pix, hsync, vsync, hblank, vblank}), 16'(e));
    for (int i = 0; i < 15; i++)
      if (tbl[i].h == h_pos && tbl[i].v == v_pos)
        check("table_sync_blank", 16'({hsync, vsync, hblank, vblank}), 16'(tbl[i].exp));
    fp = (h_pos + 8) % HT;
    fv = (h_pos + 8 >= HT) ? (v_pos + 1) % VT : v_pos;
    if (fp < HA) begin
      a = ((fv / 16) % 16) * 64 + COL + fp / 8;
      if (fp % 8 == 0) check("vram_addr", 16'(vram_addr), 16'(a));
      if (fp % 8 == 2) check("charrom_addr", 16'(charrom_addr), 16'(int'(ram[a]) * 8 + (fv / 2) % 8));
    end
    since_reset++;
    h_pos++;
    if (h_pos == HT) begin
      h_pos = 0;
      v_pos = (v_pos + 1) % VT;
    end
  endtask

  initial begin : main
    logic [7:0] line0;
    tbl[0]  = '{0,  0,  4'b0000};
    tbl[1]  = '{63, 0,  4'b0000};
    tbl[2]  = '{64, 0,  4'b0010};
    tbl[3]  = '{69, 5,  4'b0010};
    tbl[4]  = '{70, 5,  4'b1010};
    tbl[5]  = '{79, 5,  4'b1010};
    tbl[6]  = '{80, 5,  4'b0010};
    tbl[7]  = '{99, 31, 4'b0010};
    tbl[8]  = '{0,  31, 4'b0000};
    tbl[9]  = '{0,  32, 4'b0001};
    tbl[10] = '{0,  33, 4'b0001};
    tbl[11] = '{0,  34, 4'b0101};
    tbl[12] = '{99, 36, 4'b0111};
    tbl[13] = '{0,  37, 4'b0001};
    tbl[14] = '{75, 35, 4'b1111};

    for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
    ram[13]    = 8'h41;
    rom[11'h208] = 8'h81;

    // Two frames of random content from reset
    do_reset(10);
    repeat (2 * HT * VT) step();

    // Line 0 of the third frame: cell 0 prefetched at the end of the previous frame
    line0 = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      line0 = {line0[6:0], pix};
    end
    check("line0_cell0_glyph", 16'(line0), 16'h0081);

    // Reset mid-frame, then an all-lit frame
    while (!(h_pos == 20 && v_pos == 10)) step();
    for (int i = 0; i < 1024; i++) ram[i] = 8'hFF;
    for (int i = 0; i < 2048; i++) rom[i] = 8'hFF;
    do_reset(8);
    repeat (HT * VT + 8) step();

`ifdef UK101_VIDEO_INVERT_EN
    for (int i = 0; i < 2048; i++) rom[i] = 8'h00;
    invert_bit = 1'b1;
    do_reset(10);
    repeat (HT * VT + 8) step();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
